// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - pipeline M stage: word load/store over a req/ack data bus with timeout abort, feeding the M/W register
module memory_stage #(
    parameter int WORD_W  = 32,
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [WORD_W-1:0] writeDataM,
    input  logic [WORD_W-1:0] ALUResultM,
    input  logic [WORD_W-1:0] pcM,
    input  logic [REG_W-1:0]  writeRegM,
    input  logic              regWriteM,
    input  logic              memWriteM,
    input  logic              mem2regM,
    input  logic              finishM,
    input  logic              validM,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [WORD_W-1:0] dmem_addr,
    output logic [WORD_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [WORD_W-1:0] dmem_rdata,
    output logic              stallM,
    output logic [WORD_W-1:0] readDataW,
    output logic [WORD_W-1:0] ALUResultW,
    output logic [WORD_W-1:0] pcW,
    output logic [REG_W-1:0]  writeRegW,
    output logic              regWriteW,
    output logic              mem2regW,
    output logic              finishW,
    output logic              validW,
    output logic              misalignW,
    output logic              busErrW
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [WORD_W-1:0] lat_addr, lat_wdata, hold_rdata;
    logic              lat_we, hold_err;

    logic              memop, issue, timeout_hit;
    logic              req_c, stall_c;
    logic              w_load, w_bubble, w_err;
    logic [WORD_W-1:0] w_rdata;

    assign memop       = validM & (memWriteM | mem2regM);
    assign issue       = (state == IDLE) & en & memop;
    assign timeout_hit = (state == WAIT) & (cnt == CNT_MAX);

    always_comb begin
        state_nx   = state;
        req_c      = 1'b0;
        stall_c    = 1'b0;
        dmem_we    = lat_we;
        dmem_addr  = lat_addr;
        dmem_wdata = lat_wdata;
        w_load     = 1'b0;
        w_bubble   = 1'b0;
        w_err      = 1'b0;
        w_rdata    = '0;
        case (state)
            IDLE: begin
                if (issue) begin
                    req_c      = 1'b1;
                    dmem_we    = memWriteM;
                    dmem_addr  = {ALUResultM[WORD_W-1:2], 2'b00};
                    dmem_wdata = writeDataM;
                    if (dmem_ack) begin
                        w_rdata = memWriteM ? '0 : dmem_rdata;
                    end else begin
                        stall_c  = 1'b1;
                        state_nx = WAIT;
                    end
                end
                w_load   = en & ~stall_c;
                w_bubble = en & stall_c;
            end
            WAIT: begin
                req_c = 1'b1;
                if (dmem_ack) begin
                    w_rdata  = lat_we ? '0 : dmem_rdata;
                    w_load   = en;
                    state_nx = en ? IDLE : DONE;
                end else if (timeout_hit) begin
                    // abort completes like an ack but flags the bus error
                    w_err    = 1'b1;
                    w_load   = en;
                    state_nx = en ? IDLE : DONE;
                end else begin
                    stall_c  = 1'b1;
                    w_bubble = en;
                end
            end
            DONE: begin
                if (en) begin
                    w_rdata  = hold_rdata;
                    w_err    = hold_err;
                    w_load   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // reset must silence the bus and the hazard unit without waiting for a clock
    assign dmem_req = req_c & ~reset;
    assign stallM   = stall_c & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_we     <= 1'b0;
            hold_rdata <= '0;
            hold_err   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state_nx != WAIT)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + CNT_W'(1);
            if (issue) begin
                lat_addr  <= {ALUResultM[WORD_W-1:2], 2'b00};
                lat_wdata <= writeDataM;
                lat_we    <= memWriteM;
            end
            if (state == WAIT && state_nx == DONE) begin
                hold_rdata <= w_rdata;
                hold_err   <= w_err;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readDataW  <= '0;
            ALUResultW <= '0;
            pcW        <= '0;
            writeRegW  <= '0;
            regWriteW  <= 1'b0;
            mem2regW   <= 1'b0;
            finishW    <= 1'b0;
            validW     <= 1'b0;
            misalignW  <= 1'b0;
            busErrW    <= 1'b0;
        end else if (w_load) begin
            readDataW  <= w_err ? '0 : w_rdata;
            ALUResultW <= ALUResultM;
            pcW        <= pcM;
            writeRegW  <= writeRegM;
            regWriteW  <= regWriteM & ~w_err;
            mem2regW   <= mem2regM;
            finishW    <= finishM;
            validW     <= validM;
            misalignW  <= memop & (ALUResultM[1:0] != 2'b00);
            busErrW    <= w_err;
        end else if (w_bubble) begin
            regWriteW <= 1'b0;
            mem2regW  <= 1'b0;
            finishW   <= 1'b0;
            validW    <= 1'b0;
            misalignW <= 1'b0;
            busErrW   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - directed and randomized checks of memory_stage against a transaction-level reference
module tb_memory_stage;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [31:0] writeDataM, ALUResultM, pcM;
    logic [4:0]  writeRegM;
    logic        regWriteM, memWriteM, mem2regM, finishM, validM;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        stallM;
    logic [31:0] readDataW, ALUResultW, pcW;
    logic [4:0]  writeRegW;
    logic        regWriteW, mem2regW, finishW, validW, misalignW, busErrW;

    memory_stage #(.WORD_W(32), .REG_W(5), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .en(en),
        .writeDataM(writeDataM), .ALUResultM(ALUResultM), .pcM(pcM), .writeRegM(writeRegM),
        .regWriteM(regWriteM), .memWriteM(memWriteM), .mem2regM(mem2regM),
        .finishM(finishM), .validM(validM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stallM(stallM),
        .readDataW(readDataW), .ALUResultW(ALUResultW), .pcW(pcW), .writeRegW(writeRegW),
        .regWriteW(regWriteW), .mem2regW(mem2regW), .finishW(finishW), .validW(validW),
        .misalignW(misalignW), .busErrW(busErrW)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // expected M/W register contents
    logic [31:0] e_rd, e_alu, e_pc;
    logic [4:0]  e_wr;
    logic        e_regw, e_m2r, e_fin, e_val, e_mis, e_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        e_rd = 0; e_alu = 0; e_pc = 0; e_wr = 0;
        e_regw = 0; e_m2r = 0; e_fin = 0; e_val = 0; e_mis = 0; e_err = 0;
    endtask

    task automatic check_w(input string ctx);
        chk({ctx, ".readDataW"}, readDataW, e_rd);
        chk({ctx, ".ALUResultW"}, ALUResultW, e_alu);
        chk({ctx, ".pcW"}, pcW, e_pc);
        chk({ctx, ".writeRegW"}, 32'(writeRegW), 32'(e_wr));
        chk({ctx, ".regWriteW"}, 32'(regWriteW), 32'(e_regw));
        chk({ctx, ".mem2regW"}, 32'(mem2regW), 32'(e_m2r));
        chk({ctx, ".finishW"}, 32'(finishW), 32'(e_fin));
        chk({ctx, ".validW"}, 32'(validW), 32'(e_val));
        chk({ctx, ".misalignW"}, 32'(misalignW), 32'(e_mis));
        chk({ctx, ".busErrW"}, 32'(busErrW), 32'(e_err));
    endtask

    // One instruction from entry in M until it retires into W.
    // ack_delay: cycles after the request is first issued until ack (-1: never).
    task automatic run_instr(input string name,
                             input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc,
                             input logic [4:0] wr, input logic rw, input logic mw, input logic m2r,
                             input logic fin, input logic vld, input int ack_delay,
                             input int en_lo_from, input int en_lo_to, input bit en_rand,
                             input logic [31:0] rdat);
        logic        memop, is_load, en_c, issue_now, active_now, ack_c, to_c, exp_stall;
        logic [31:0] r_rd;
        logic        r_err;
        int          phase, k, cur_k, it;
        ALUResultM = alu; writeDataM = wd; pcM = pc; writeRegM = wr;
        regWriteM = rw; memWriteM = mw; mem2regM = m2r; finishM = fin; validM = vld;
        memop   = vld & (mw | m2r);
        is_load = memop & !mw;
        phase = 0; k = 0; it = 0; r_rd = 0; r_err = 0;
        while (phase != 3 && it < 200) begin
            @(negedge clk);
            en_c = en_rand ? ($urandom_range(0, 3) != 0) : !(it >= en_lo_from && it <= en_lo_to);
            en = en_c;
            issue_now  = (phase == 0) & memop & en_c;
            cur_k      = issue_now ? 0 : k;
            active_now = issue_now | (phase == 1);
            ack_c      = active_now & (cur_k == ack_delay);
            to_c       = (phase == 1) & !ack_c & (cur_k == TIMEOUT - 1);
            dmem_ack   = ack_c;
            dmem_rdata = ack_c ? rdat : $urandom();
            exp_stall  = active_now & !ack_c & !to_c;
            #1;
            chk({name, ".dmem_req"}, 32'(dmem_req), 32'(active_now));
            chk({name, ".stallM"}, 32'(stallM), 32'(exp_stall));
            if (active_now) begin
                chk({name, ".dmem_addr"}, dmem_addr, {alu[31:2], 2'b00});
                chk({name, ".dmem_we"}, 32'(dmem_we), 32'(mw));
                if (mw) chk({name, ".dmem_wdata"}, dmem_wdata, wd);
            end
            if (active_now & (ack_c | to_c)) begin
                r_err = to_c;
                r_rd  = (ack_c & is_load) ? rdat : 32'h0;
                phase = en_c ? 4 : 2;
            end else if (phase == 2) begin
                if (en_c) phase = 4;
            end else if (phase == 0 & !memop) begin
                if (en_c) phase = 4;
            end else if (issue_now) begin
                phase = 1;
            end
            if (phase == 4) begin
                e_rd = r_err ? 32'h0 : r_rd; e_alu = alu; e_pc = pc; e_wr = wr;
                e_regw = rw & !r_err; e_m2r = m2r; e_fin = fin; e_val = vld;
                e_mis = memop & (alu[1:0] != 2'b00); e_err = r_err;
                phase = 3;
            end else if (en_c & exp_stall) begin
                e_regw = 0; e_m2r = 0; e_fin = 0; e_val = 0; e_mis = 0; e_err = 0;
            end
            @(posedge clk);
            #1;
            dmem_ack = 1'b0;
            check_w(name);
            if (active_now) k = cur_k + 1;
            it++;
        end
        if (phase != 3) begin
            total++; bad++;
            $error("FAIL %s.retire: observed=no_retire expected=retire_within_200", name);
        end
    endtask

    initial begin
        logic [31:0] a;
        int d, r;
        reset = 1'b1; en = 1'b0; dmem_ack = 1'b0; dmem_rdata = 0;
        ALUResultM = 0; writeDataM = 0; pcM = 0; writeRegM = 0;
        regWriteM = 0; memWriteM = 0; mem2regM = 0; finishM = 0; validM = 0;
        model_clear();
        #12;
        chk("reset.dmem_req", 32'(dmem_req), 32'd0);
        chk("reset.stallM", 32'(stallM), 32'd0);
        check_w("reset");
        @(negedge clk); reset = 1'b0;

        run_instr("alu", 32'h2A, 32'h0, 32'h1000, 5'd5, 1, 0, 0, 0, 1, -1, -1, -1, 0, 32'h0);
        run_instr("store", 32'h100, 32'hDEADBEEF, 32'h1004, 5'd0, 0, 1, 0, 0, 1, 0, -1, -1, 0, 32'h0);
        run_instr("load3", 32'h204, 32'h0, 32'h1008, 5'd7, 1, 0, 1, 0, 1, 3, -1, -1, 0, 32'h12345678);
        run_instr("load_en_drop", 32'h308, 32'h0, 32'h100C, 5'd9, 1, 0, 1, 0, 1, 2, 1, 3, 0, 32'hCAFEF00D);
        run_instr("timeout", 32'h400, 32'h0, 32'h1010, 5'd3, 1, 0, 1, 0, 1, -1, -1, -1, 0, 32'h0);
        run_instr("timeout_en_low", 32'h404, 32'h0, 32'h1014, 5'd4, 1, 0, 1, 0, 1, -1, 14, 17, 0, 32'h0);
        run_instr("misalign", 32'h103, 32'h0, 32'h1018, 5'd6, 1, 0, 1, 1, 1, 1, -1, -1, 0, 32'hA5A5A5A5);
        run_instr("invalid_mem", 32'h500, 32'h11, 32'h101C, 5'd8, 1, 1, 1, 0, 0, 0, -1, -1, 0, 32'h0);
        run_instr("ack_at_limit", 32'h600, 32'h0, 32'h1020, 5'd2, 1, 0, 1, 0, 1, 15, -1, -1, 0, 32'h0BADF00D);

        // reset while a load is waiting on the bus
        @(negedge clk);
        en = 1; ALUResultM = 32'h700; mem2regM = 1; memWriteM = 0; validM = 1; dmem_ack = 0;
        @(posedge clk);
        @(negedge clk);
        #1 chk("midwait.stallM_before", 32'(stallM), 32'd1);
        reset = 1'b1;
        #1;
        model_clear();
        chk("midwait.dmem_req", 32'(dmem_req), 32'd0);
        chk("midwait.stallM", 32'(stallM), 32'd0);
        check_w("midwait");
        @(negedge clk); reset = 1'b0;
        run_instr("post_reset", 32'h804, 32'h0, 32'h1100, 5'd1, 1, 0, 1, 0, 1, 1, -1, -1, 0, 32'h55AA55AA);

        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            d = (r < 7) ? $urandom_range(0, 4) : (r == 7) ? -1 : (r == 8) ? 14 : 15;
            a = $urandom();
            run_instr("rand", a, $urandom(), $urandom(), 5'($urandom()),
                      1'($urandom()), 1'($urandom()), 1'($urandom()), 1'($urandom()),
                      ($urandom_range(0, 7) != 0), d, -1, -1, 1, $urandom());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline M stage. Consumes the execute-stage register outputs, performs word loads/stores on a req/ack data-memory bus, and registers results into the M/W pipeline register for writeback.
- Drives stallM to the hazard unit while a bus transaction is outstanding.
- Supports multi-cycle memory with a timeout abort.

Parameters:
- WORD_W, 32, data/address width.
- REG_W, 5, register index width.
- TIMEOUT, 16, maximum WAIT cycles before abort (>=2).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- en  in  1  pipeline enable from hazard unit; 0 freezes the M/W register
- writeDataM  in  WORD_W  store data
- ALUResultM  in  WORD_W  byte address, or ALU result for non-memory ops
- pcM  in  WORD_W  instruction PC
- writeRegM  in  REG_W  destination register
- regWriteM, memWriteM, mem2regM, finishM, validM  in  1 each  control from execute register
- dmem_req  out  1  bus request
- dmem_we  out  1  1=store, 0=load
- dmem_addr  out  WORD_W  word-aligned address ({addr[W-1:2],2'b00})
- dmem_wdata  out  WORD_W  store data
- dmem_ack  in  1  transaction complete; dmem_rdata valid in same cycle for loads
- dmem_rdata  in  WORD_W  load data
- stallM  out  1  hold F/D/E stages and the execute register
- readDataW, ALUResultW, pcW  out  WORD_W  W-stage registers
- writeRegW  out  REG_W
- regWriteW, mem2regW, finishW, validW, misalignW, busErrW  out  1 each

Behaviour:
- memop = validM & (memWriteM | mem2regM). With validM=0, no bus activity regardless of other controls.
- FSM states: IDLE, WAIT, DONE. Reset state is IDLE. Reset is asynchronous: dmem_req and stallM drop immediately, all W outputs go to 0, and the timeout counter clears, including mid-transaction.
- IDLE:
  - If en & memop: dmem_req=1 combinationally, with addr, we and wdata taken from M inputs; these values are also latched.
  - If dmem_ack arrives in the same cycle, the access completes with zero stall.
  - Otherwise go to WAIT.
  - If en=0, no request is issued.
- WAIT:
  - dmem_req=1, driven from the latched values. The request must stay stable until ack, even if en drops.
  - Counter increments each cycle.
  - On ack: if en=1, go to IDLE and load the W register using dmem_rdata. If en=0, latch rdata into a hold register and go to DONE.
  - If the counter reaches TIMEOUT-1 without ack: abort, dmem_req=0 next cycle, then treat as completion with busErr.
- DONE: dmem_req=0, stallM=0. When en=1, load the W register from the hold register and go to IDLE.
- stallM = (IDLE & en & memop & !ack) | (WAIT & !ack & !timeout_hit).
- W register update:
  - Loads on en & !stallM with the M inputs.
  - readDataW = load ? rdata : 0.
  - misalignW = memop & (ALUResultM[1:0] != 0). The access is still performed aligned.
  - busErrW = 1 on the abort completion; in that case regWriteW is forced to 0 and readDataW=0.
- When en=1 & stallM=1, the W register loads a bubble: all W controls 0, validW=0, so no double writeback.
- When en=0, the W register holds.
- Non-memory valid instructions pass through in 1 cycle with no bus activity.
- Latency: a memory op reaches W one cycle after its ack cycle. A non-memory op reaches W at the next clk edge.
- The counter is WORD-agnostic, width clog2(TIMEOUT), and does not wrap; it saturates at abort.
- Back-to-back memops: a new request may issue in the cycle after completion (IDLE).

Test Plan:
- ALU op (validM=1, regWriteM=1, ALUResultM=0x2A, writeRegM=5) -> no dmem_req; next cycle ALUResultW=0x2A, writeRegW=5, validW=1.
- Store (addr 0x100, wdata 0xDEADBEEF), ack same cycle -> dmem_req=1, we=1, addr=0x100, stallM=0; next cycle validW=1, readDataW=0.
- Load (addr 0x204), ack after 3 cycles with rdata 0x12345678 -> stallM=1 for 3 cycles; W shows bubbles (validW=0) meanwhile; readDataW=0x12345678, mem2regW=1 one cycle after ack.
- Load, en dropped during WAIT, ack arrives at en=0 -> DONE; rdata held; W loads 0x... when en returns; dmem_req=0 in DONE.
- Load with no ack, TIMEOUT=16 -> stallM high 15 cycles, then busErrW=1, regWriteW=0.
- Load at 0x103 -> dmem_addr=0x100, misalignW=1.
- Reset asserted mid-WAIT -> dmem_req and stallM drop same cycle; all W outputs 0.
